// File: rtl/btn_event_ctrl.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events and queues them
// for a valid/ready consumer. Define BTN_EVT_REPEAT_EN to enable auto-repeat while held.
module btn_event_ctrl #(
  parameter int unsigned LONG_TICKS = 40,
  parameter int unsigned REP_TICKS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic [2:0] BLVL,
  output logic       EVT_VALID,
  input  logic       EVT_READY,
  output logic [1:0] EVT_BTN,
  output logic [1:0] EVT_KIND,
  output logic       OVF,
  input  logic       OVF_CLR
);

  localparam int unsigned NB = 3;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] K_PRESS   = 2'b00;
  localparam logic [1:0] K_RELEASE = 2'b01;
  localparam logic [1:0] K_LONG    = 2'b10;
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [1:0] K_REPEAT  = 2'b11;
`endif

  if (LONG_TICKS < 2 || LONG_TICKS > 255 || REP_TICKS < 2 || REP_TICKS > 255 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("btn_event_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HELD} st_t;

  typedef struct packed {
    logic [1:0] btn;
    logic [1:0] kind;
  } evt_t;

  st_t           st_q   [NB];
  st_t           st_d   [NB];
  logic [7:0]    cnt_q  [NB];
  logic [7:0]    cnt_d  [NB];
  logic [NB-1:0] fire_c;
  logic [1:0]    kind_c [NB];

  logic [NB-1:0] pend_q, pend_d;
  logic [1:0]    pend_kind_q [NB];
  logic [1:0]    sel_c;
  logic          push_c;
  evt_t          push_data_c;

  evt_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_d, wr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          pop_c, full_c, push_ok_c, drop_c;
  evt_t          head_c;

  // Per-button state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NB; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-button next state; the PRESS tick counts as the first held tick for LONG
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      fire_c[i] = 1'b0;
      kind_c[i] = K_PRESS;
      if (TICK) begin
        case (st_q[i])
          S_IDLE: begin
            if (BLVL[i]) begin
              fire_c[i] = 1'b1;
              kind_c[i] = K_PRESS;
              cnt_d[i]  = 8'd0;
              st_d[i]   = S_DOWN;
            end
          end
          S_DOWN: begin
            if (!BLVL[i]) begin
              fire_c[i] = 1'b1;
              kind_c[i] = K_RELEASE;
              st_d[i]   = S_IDLE;
            end else if (cnt_q[i] == 8'(LONG_TICKS - 2)) begin
              fire_c[i] = 1'b1;
              kind_c[i] = K_LONG;
              cnt_d[i]  = 8'd0;
              st_d[i]   = S_HELD;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
          S_HELD: begin
            if (!BLVL[i]) begin
              fire_c[i] = 1'b1;
              kind_c[i] = K_RELEASE;
              st_d[i]   = S_IDLE;
            end
`ifdef BTN_EVT_REPEAT_EN
            else if (cnt_q[i] == 8'(REP_TICKS - 1)) begin
              fire_c[i] = 1'b1;
              kind_c[i] = K_REPEAT;
              cnt_d[i]  = 8'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
`endif
          end
          default: st_d[i] = S_IDLE;
        endcase
      end
    end
  end

  // Drain the lowest pending slot each cycle
  always_comb begin
    sel_c = 2'd0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_c = 2'(i);
    end
    push_c           = |pend_q;
    push_data_c.btn  = sel_c;
    push_data_c.kind = pend_kind_q[sel_c];
    pend_d           = (pend_q & ~(push_c ? (3'(1) << sel_c) : 3'd0)) | fire_c;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q <= '0;
      for (int i = 0; i < NB; i++) pend_kind_q[i] <= 2'd0;
    end else begin
      pend_q <= pend_d;
      for (int i = 0; i < NB; i++) begin
        if (fire_c[i]) pend_kind_q[i] <= kind_c[i];
      end
    end
  end

  // Queue control; the head register is preloaded with whatever will sit at rd_d
  always_comb begin
    pop_c     = EVT_VALID & EVT_READY;
    full_c    = (fcnt_q == CW'(FIFO_DEPTH));
    push_ok_c = push_c & (~full_c | pop_c);
    drop_c    = push_c & full_c & ~pop_c;
    rd_d      = rd_q + AW'(pop_c);
    wr_d      = wr_q + AW'(push_ok_c);
    fcnt_d    = fcnt_q + CW'(push_ok_c) - CW'(pop_c);
    if (push_ok_c && (wr_q == rd_d)) head_c = push_data_c;
    else                             head_c = mem_q[rd_d];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      fcnt_q    <= '0;
      EVT_VALID <= 1'b0;
      EVT_BTN   <= 2'd0;
      EVT_KIND  <= 2'd0;
      OVF       <= 1'b0;
    end else begin
      if (push_ok_c) mem_q[wr_q] <= push_data_c;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      fcnt_q    <= fcnt_d;
      EVT_VALID <= (fcnt_d != '0);
      if (fcnt_d != '0) begin
        EVT_BTN  <= head_c.btn;
        EVT_KIND <= head_c.kind;
      end
      if (drop_c)       OVF <= 1'b1;
      else if (OVF_CLR) OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: tick vector table plus hand-written
// long-press, overflow, full-queue and reset sequences.
module tb_btn_event_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       TICK = 1'b0;
  logic [2:0] BLVL = 3'b000;
  logic       EVT_VALID;
  logic       EVT_READY = 1'b1;
  logic [1:0] EVT_BTN;
  logic [1:0] EVT_KIND;
  logic       OVF;
  logic       OVF_CLR = 1'b0;

  localparam logic [1:0] KP = 2'b00;
  localparam logic [1:0] KR = 2'b01;
  localparam logic [1:0] KL = 2'b10;
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [1:0] KT = 2'b11;
`endif

  int total = 0;
  int bad   = 0;

  btn_event_ctrl dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .BLVL(BLVL),
    .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY),
    .EVT_BTN(EVT_BTN), .EVT_KIND(EVT_KIND),
    .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] blvl;
    int         n;
    logic [5:0] btns;
    logic [5:0] kinds;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // One TICK, then record EVT_* for cycles t+2..t+5 with READY held high
  task automatic tick_collect(input logic [2:0] b, output logic [3:0] vm,
                              output logic [7:0] btns, output logic [7:0] kinds);
    @(posedge CLK); #1;
    TICK = 1'b1; BLVL = b;
    @(posedge CLK); #1;
    TICK = 1'b0;
    vm = '0; btns = '0; kinds = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (EVT_VALID) begin
        vm[c]          = 1'b1;
        btns[2*c +: 2] = EVT_BTN;
        kinds[2*c +: 2] = EVT_KIND;
      end
    end
  endtask

  task automatic tick_only(input logic [2:0] b);
    @(posedge CLK); #1;
    TICK = 1'b1; BLVL = b;
    @(posedge CLK); #1;
    TICK = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic chk_head(input string nm, input logic v, input logic [1:0] b, input logic [1:0] k);
    chk(nm, 32'({EVT_VALID, EVT_BTN, EVT_KIND}), 32'({v, b, k}));
  endtask

  task automatic chk_collect(input string nm, input logic [2:0] b, input int n,
                             input logic [5:0] eb, input logic [5:0] ek);
    logic [3:0] vm;
    logic [7:0] bs, ks;
    tick_collect(b, vm, bs, ks);
    chk({nm, "_vm"}, 32'(vm), 32'((1 << n) - 1));
    chk({nm, "_btn"}, 32'(bs), 32'({2'b00, eb}));
    chk({nm, "_kind"}, 32'(ks), 32'({2'b00, ek}));
  endtask

  // Button 1 held for ticks 1..last, released on tick last+1
  task automatic run_hold(input int last);
    logic [3:0] vm;
    logic [7:0] bs, ks;
    logic       ev;
    logic [1:0] ek;
    for (int tk = 1; tk <= last + 1; tk++) begin
      tick_collect((tk <= last) ? 3'b010 : 3'b000, vm, bs, ks);
      ev = 1'b0;
      ek = KP;
      if (tk == 1)              begin ev = 1'b1; ek = KP; end
      else if (tk == last + 1)  begin ev = 1'b1; ek = KR; end
      else if (tk == 40)        begin ev = 1'b1; ek = KL; end
`ifdef BTN_EVT_REPEAT_EN
      else if (tk > 40 && ((tk - 40) % 8) == 0) begin ev = 1'b1; ek = KT; end
`endif
      chk($sformatf("hold%0d_t%0d_vm", last, tk), 32'(vm), ev ? 32'd1 : 32'd0);
      if (ev) chk($sformatf("hold%0d_t%0d_evt", last, tk), 32'({bs[1:0], ks[1:0]}), 32'({2'd1, ek}));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] db [4];
    logic [1:0] dk [4];

    //           blvl    n  btns          kinds
    tbl[0]  = '{3'b001, 1, 6'b000000, 6'b000000};
    tbl[1]  = '{3'b000, 1, 6'b000000, 6'b000001};
    tbl[2]  = '{3'b111, 3, 6'b100100, 6'b000000};
    tbl[3]  = '{3'b101, 1, 6'b000001, 6'b000001};
    tbl[4]  = '{3'b000, 2, 6'b001000, 6'b000101};
    tbl[5]  = '{3'b010, 1, 6'b000001, 6'b000000};
    tbl[6]  = '{3'b000, 1, 6'b000001, 6'b000001};
    tbl[7]  = '{3'b000, 0, 6'b000000, 6'b000000};
    tbl[8]  = '{3'b110, 2, 6'b001001, 6'b000000};
    tbl[9]  = '{3'b011, 2, 6'b001000, 6'b000100};
    tbl[10] = '{3'b000, 2, 6'b000100, 6'b000101};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk_head("reset_head", 1'b0, 2'd0, 2'd0);
    chk("reset_ovf", 32'(OVF), 32'd0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_head("idle_head", 1'b0, 2'd0, 2'd0);

    // Single-tick vectors
    for (int i = 0; i < 11; i++) begin
      chk_collect($sformatf("vec%0d", i), tbl[i].blvl, tbl[i].n, tbl[i].btns, tbl[i].kinds);
    end

    // Long press, then long press held further
    run_hold(40);
    run_hold(56);

    // Overflow with stalled consumer, clear, then ordered drain
    EVT_READY = 1'b0;
    tick_only(3'b011);
    tick_only(3'b000);
    tick_only(3'b011);
    chk("ovf_set", 32'(OVF), 32'd1);
    chk_head("ovf_head", 1'b1, 2'd0, KP);
    @(posedge CLK); #1;
    chk_head("stall_head", 1'b1, 2'd0, KP);
    OVF_CLR = 1'b1;
    @(posedge CLK); #1;
    OVF_CLR = 1'b0;
    chk("ovf_clr", 32'(OVF), 32'd0);
    db = '{2'd0, 2'd1, 2'd0, 2'd1};
    dk = '{KP, KP, KR, KR};
    EVT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("ovf_drain%0d", k), 1'b1, db[k], dk[k]);
      @(posedge CLK); #1;
    end
    chk_head("ovf_drain_empty", 1'b0, 2'd1, KR);
    chk_collect("ovf_rel", 3'b000, 2, 6'b000100, 6'b000101);

    // Full queue: push coincides with pop
    EVT_READY = 1'b0;
    tick_only(3'b011);
    tick_only(3'b000);
    chk("full_noovf", 32'(OVF), 32'd0);
    @(posedge CLK); #1;
    TICK = 1'b1; BLVL = 3'b100;
    @(posedge CLK); #1;
    TICK = 1'b0;
    EVT_READY = 1'b1;
    @(posedge CLK); #1;
    EVT_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("full_pushpop_ovf", 32'(OVF), 32'd0);
    db = '{2'd1, 2'd0, 2'd1, 2'd2};
    dk = '{KP, KR, KR, KP};
    EVT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_head($sformatf("full_drain%0d", k), 1'b1, db[k], dk[k]);
      @(posedge CLK); #1;
    end
    chk("full_drain_empty", 32'(EVT_VALID), 32'd0);
    chk_collect("full_rel", 3'b000, 1, 6'b000010, 6'b000001);

    // Reset mid-press with full queue and OVF set
    EVT_READY = 1'b0;
    tick_only(3'b111);
    tick_only(3'b011);
    tick_only(3'b111);
    chk("pre_rst_ovf", 32'(OVF), 32'd1);
    chk_head("pre_rst_head", 1'b1, 2'd0, KP);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_head("post_rst_head", 1'b0, 2'd0, 2'd0);
    chk("post_rst_ovf", 32'(OVF), 32'd0);
    EVT_READY = 1'b1;
    BLVL = 3'b100;
    repeat (6) @(posedge CLK);
    #1;
    chk("no_tick_no_evt", 32'(EVT_VALID), 32'd0);
    chk_collect("rst_press", 3'b100, 1, 6'b000010, 6'b000000);
    chk_collect("rst_rel", 3'b000, 1, 6'b000010, 6'b000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
